// File: rtl/decoder_mac_pkg.sv
// Shared types and width helpers for the decoder MAC / requantiser slice.
// Optional build macro used by this slice: DECODER_MAC_RELU_EN.
package decoder_mac_pkg;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        RQ  = 2'd1,
        OUT = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Accumulator wide enough that num_terms products plus the bias cannot wrap.
    function automatic int acc_width(input int prod_w, input int num_terms);
        return prod_w + clog2(num_terms) + 1;
    endfunction

    // Saturation limits for a signed width w.
    function automatic longint out_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint out_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    localparam int     DEF_OUT_W = 16;
    localparam longint OUT_MAX   = out_max(DEF_OUT_W);
    localparam longint OUT_MIN   = out_min(DEF_OUT_W);

endpackage

// File: rtl/decoder_rq_sat.sv
// Combinational rounding right-shift and signed saturation of the neuron sum.
// With DECODER_MAC_RELU_EN defined, negative saturated results clamp to zero;
// sat reports only the saturation step.
module decoder_rq_sat
    import decoder_mac_pkg::*;
#(
    parameter int ACC_W = 29,
    parameter int SHIFT = 6,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] act,
    output logic                    sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int R_W     = ACC_W + 1;
    localparam int HALF_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [R_W-1:0] HALF    = (SHIFT > 0) ? R_W'(longint'(1) << HALF_SH) : '0;
    localparam logic signed [R_W-1:0] SAT_MAX = R_W'(out_max(OUT_W));
    localparam logic signed [R_W-1:0] SAT_MIN = R_W'(out_min(OUT_W));

    logic signed [R_W-1:0] sum_x;
    logic signed [R_W-1:0] rounded;

    // Round half toward +inf, arithmetic shift, then clip to the output range.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        act     = '0;
        sat     = 1'b0;
        sum_x   = {sum[ACC_W-1], sum};
        rounded = (sum_x + HALF) >>> SHIFT;
        if (rounded > SAT_MAX) begin
            act = SAT_MAX[OUT_W-1:0];
            sat = 1'b1;
        end else if (rounded < SAT_MIN) begin
            act = SAT_MIN[OUT_W-1:0];
            sat = 1'b1;
        end else begin
            act = rounded[OUT_W-1:0];
        end
`ifdef DECODER_MAC_RELU_EN
        if (act[OUT_W-1]) begin
            act = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/decoder_mac_requant.sv
// Dense-layer neuron: accumulates NUM_TERMS signed products, adds bias,
// requantises through decoder_rq_sat and streams the activation out over
// valid/ready. Optional build macro: DECODER_MAC_RELU_EN (ReLU after saturation).
module decoder_mac_requant
    import decoder_mac_pkg::*;
#(
    parameter int PROD_W    = 22,
    parameter int NUM_TERMS = 64,
    parameter int BIAS_W    = 16,
    parameter int SHIFT     = 6,
    parameter int OUT_W     = DEF_OUT_W
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic signed [BIAS_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     sat_flag
);

    localparam int ACC_W = acc_width(PROD_W, NUM_TERMS);
    localparam int CNT_W = (clog2(NUM_TERMS) > 0) ? clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] rq_data;
    logic                    rq_sat;

    // Running sum including the product currently on the input.
    always_comb begin
        acc_next = acc + ACC_W'(in_prod);
    end

    decoder_rq_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_rq_sat (
        .sum (sum),
        .act (rq_data),
        .sat (rq_sat)
    );

    // Control FSM: accumulate a group, requantise once, then hold the result until taken.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ACC;
            count     <= '0;
            acc       <= '0;
            sum       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                ACC: begin
                    if (in_valid) begin
                        if (count == LAST) begin
                            sum      <= acc_next + ACC_W'(bias);
                            acc      <= '0;
                            count    <= '0;
                            in_ready <= 1'b0;
                            state    <= RQ;
                        end else begin
                            acc   <= acc_next;
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                RQ: begin
                    out_data  <= rq_data;
                    sat_flag  <= rq_sat;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACC;
                    end
                end
                default: begin
                    state    <= ACC;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_mac_requant.sv
// Scoreboard bench for decoder_mac_requant with NUM_TERMS=4, SHIFT=6.
// Expected activations are hand-computed; DECODER_MAC_RELU_EN selects the
// ReLU-clamped expectations.
module tb_decoder_mac_requant;
    import decoder_mac_pkg::*;

    localparam int PROD_W    = 22;
    localparam int NUM_TERMS = 4;
    localparam int BIAS_W    = 16;
    localparam int SHIFT     = 6;
    localparam int OUT_W     = 16;
    localparam int PMAX      = 2097151;   // 2^21-1
    localparam int PMIN      = -2097152;  // -2^21
    localparam int JUNK_BIAS = 12345;     // driven on non-final products; must be ignored

    logic                     ap_clk = 1'b0;
    logic                     ap_rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [PROD_W-1:0] in_prod = '0;
    logic signed [BIAS_W-1:0] bias = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [OUT_W-1:0]  out_data;
    logic                     sat_flag;

    decoder_mac_requant #(
        .PROD_W    (PROD_W),
        .NUM_TERMS (NUM_TERMS),
        .BIAS_W    (BIAS_W),
        .SHIFT     (SHIFT),
        .OUT_W     (OUT_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        logic                    sat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   hs_last = 0;
    int   hs_prev = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected activation after the optional ReLU stage.
    function automatic logic signed [OUT_W-1:0] post_act(input int r);
`ifdef DECODER_MAC_RELU_EN
        return (r < 0) ? '0 : OUT_W'(r);
`else
        return OUT_W'(r);
`endif
    endfunction

    task automatic expect_out(input int d, input bit s);
        exp_t e;
        e.data = post_act(d);
        e.sat  = s;
        sb.push_back(e);
    endtask

    // Present one product and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic put(input int p, input int b);
        bit accepted;
        int guard;
        guard    = 0;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_prod  = PROD_W'(p);
        bias     = BIAS_W'(b);
        while (!accepted && guard < 200) begin
            accepted = in_ready;
            @(posedge ap_clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL put_timeout: in_ready stayed %0d, required 1", in_ready);
        end
    endtask

    task automatic group(input int p0, input int p1, input int p2, input int p3,
                         input int b, input int d, input bit s);
        expect_out(d, s);
        put(p0, JUNK_BIAS);
        put(p1, JUNK_BIAS);
        put(p2, JUNK_BIAS);
        put(p3, b);
    endtask

    task automatic wait_valid();
        int g;
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge ap_clk);
            #1;
            g++;
        end
        check("wait_out_valid", out_valid, 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() > 0 && g < 100) begin
            @(posedge ap_clk);
            #1;
            g++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: compare each accepted activation against the scoreboard head.
    always @(negedge ap_clk) begin
        if (ap_rst_n && out_valid && out_ready) begin
            hs_prev = hs_last;
            hs_last = cyc;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0d with nothing expected", out_data);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
                check("sat_flag", sat_flag, mon_e.sat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_sat_flag", sat_flag, 0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // T1: 640 -> (640+32)>>6 = 10; result shows in the second cycle after the last product.
        expect_out(10, 1'b0);
        put(64, JUNK_BIAS);
        put(128, JUNK_BIAS);
        put(192, JUNK_BIAS);
        put(256, 0);
        check("lat_valid_t1", out_valid, 0);
        check("lat_ready_t1", in_ready, 0);
        @(posedge ap_clk);
        #1;
        check("lat_valid_t2", out_valid, 1);
        drain();

        // T2: rounding around the half point
        group(0, 0, 0, 0, 32, 1, 1'b0);
        group(0, 0, 0, 0, -33, -1, 1'b0);
        group(0, 0, 0, 0, -32, 0, 1'b0);
        group(0, 0, 0, 0, 31, 0, 1'b0);

        // T3: saturation and its exact boundaries
        group(PMAX, PMAX, PMAX, PMAX, 0, int'(OUT_MAX), 1'b1);
        group(PMIN, PMIN, PMIN, PMIN, 0, int'(OUT_MIN), 1'b1);
        group(2097088, 0, 0, 0, 0, 32767, 1'b0);
        group(PMAX, 1, 0, 0, 0, 32767, 1'b1);
        group(PMIN, 0, 0, 0, 0, -32768, 1'b0);
        group(PMIN, -64, 0, 0, 0, -32768, 1'b1);
        drain();

        // T4: backpressure holds the result and blocks new products
        out_ready = 1'b0;
        group(100, 200, 300, 400, 0, 16, 1'b0);
        wait_valid();
        in_valid = 1'b1;
        in_prod  = PROD_W'(1000);
        bias     = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 16);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge ap_clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        group(64, 64, 64, 64, 0, 4, 1'b0);
        drain();

        // T5: reset mid-group discards the partial sum
        put(7, JUNK_BIAS);
        put(9, JUNK_BIAS);
        ap_rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        group(320, 320, 320, 320, 0, 20, 1'b0);
        drain();

        // Reset while a result is pending discards it
        out_ready = 1'b0;
        group(640, 0, 0, 0, 0, 10, 1'b0);
        wait_valid();
        ap_rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("rst_pend_out_valid", out_valid, 0);
        @(posedge ap_clk);
        #1;
        ap_rst_n  = 1'b1;
        out_ready = 1'b1;

        // T6: sum -6400 -> -100, or 0 with ReLU
        group(-1600, -1600, -1600, -1600, 0, -100, 1'b0);

        // Throughput: back-to-back groups complete NUM_TERMS+2 cycles apart
        group(64, 0, 0, 0, 0, 1, 1'b0);
        drain();
        check("throughput", hs_last - hs_prev, NUM_TERMS + 2);

        repeat (3) @(posedge ap_clk);
        check("final_scoreboard", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
